// File: rtl/mc_chroma_ref_fetch_if.sv
// Bundle of command, reference-buffer and window signals for mc_chroma_ref_fetch.
// Optional stall_cnt_o exists only when MC_CHROMA_FETCH_STALL_CNT_EN is defined.
interface mc_chroma_ref_fetch_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int COORD_W     = 6
);
   logic                     start_i;
   logic [1:0]               blk_w_i;
   logic [1:0]               blk_h_i;
   logic [2:0]               fracx_i;
   logic [2:0]               fracy_i;
   logic                     ref_rd_en_o;
   logic [COORD_W-1:0]       ref_x_o;
   logic [COORD_W-1:0]       ref_y_o;
   logic                     ref_gnt_i;
   logic [4*PIXEL_WIDTH-1:0] ref_data_i;
   logic                     blk_start_o;
   logic [2:0]               fracx_o;
   logic [2:0]               fracy_o;
   logic                     ref_valid_o;
   logic [PIXEL_WIDTH-1:0]   refuv_p0_o;
   logic [PIXEL_WIDTH-1:0]   refuv_p1_o;
   logic [PIXEL_WIDTH-1:0]   refuv_p2_o;
   logic [PIXEL_WIDTH-1:0]   refuv_p3_o;
   logic                     busy_o;
   logic                     done_o;
`ifdef MC_CHROMA_FETCH_STALL_CNT_EN
   logic [15:0]              stall_cnt_o;
`endif

   modport master (
      input  start_i, blk_w_i, blk_h_i, fracx_i, fracy_i, ref_gnt_i, ref_data_i,
      output ref_rd_en_o, ref_x_o, ref_y_o, blk_start_o, fracx_o, fracy_o,
      output ref_valid_o, refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o,
`ifdef MC_CHROMA_FETCH_STALL_CNT_EN
      output stall_cnt_o,
`endif
      output busy_o, done_o
   );

   modport slave (
      output start_i, blk_w_i, blk_h_i, fracx_i, fracy_i, ref_gnt_i, ref_data_i,
      input  ref_rd_en_o, ref_x_o, ref_y_o, blk_start_o, fracx_o, fracy_o,
      input  ref_valid_o, refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o,
`ifdef MC_CHROMA_FETCH_STALL_CNT_EN
      input  stall_cnt_o,
`endif
      input  busy_o, done_o
   );
endinterface

// File: rtl/mc_chroma_ref_fetch.sv
// Chroma reference fetcher: 4-tap windows in column-major order within 4-row strips.
// Optional stall counter enabled by defining MC_CHROMA_FETCH_STALL_CNT_EN.
module mc_chroma_ref_fetch #(
   parameter int PIXEL_WIDTH = 8,
   parameter int COORD_W     = 6
) (
   input logic                   clk,
   input logic                   rst,
   mc_chroma_ref_fetch_if.master bus
);

   typedef enum logic [2:0] {IDLE, START, FETCH, DRAIN, DONE} state_t;

   state_t     state_q, state_d;
   logic [1:0] w_code_q, h_code_q;
   logic [2:0] fracx_q, fracy_q;
   logic [2:0] r_q;
   logic [4:0] c_q;
   logic [2:0] s_q;
   logic       valid_q;

   logic       rd_en, fire, last_beat;
   logic [2:0] r_max;
   logic [4:0] c_max;
   logic [2:0] s_max;
   logic [5:0] w_pix;
   logic [3:0] strips;

   assign w_pix     = 6'd4 << w_code_q;
   assign strips    = 4'd1 << h_code_q;
   assign r_max     = (fracy_q != 3'd0) ? 3'd6 : 3'd3;
   assign c_max     = 5'(w_pix - 6'd1);
   assign s_max     = 3'(strips - 4'd1);
   assign rd_en     = (state_q == FETCH);
   assign fire      = rd_en & bus.ref_gnt_i;
   assign last_beat = fire && (r_q == r_max) && (c_q == c_max) && (s_q == s_max);

   always_comb begin
      state_d         = state_q;
      bus.blk_start_o = 1'b0;
      bus.done_o      = 1'b0;
      bus.busy_o      = (state_q != IDLE);
      unique case (state_q)
         IDLE:  if (bus.start_i) state_d = START;
         START: begin
            bus.blk_start_o = 1'b1;
            state_d         = FETCH;
         end
         FETCH: if (last_beat) state_d = DRAIN;
         DRAIN: state_d = DONE;
         DONE: begin
            bus.done_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         w_code_q <= '0;
         h_code_q <= '0;
         fracx_q  <= '0;
         fracy_q  <= '0;
         r_q      <= '0;
         c_q      <= '0;
         s_q      <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= fire;
         if (state_q == IDLE && bus.start_i) begin
            w_code_q <= bus.blk_w_i;
            h_code_q <= bus.blk_h_i;
            fracx_q  <= bus.fracx_i;
            fracy_q  <= bus.fracy_i;
         end
         // Row is innermost, then column, then strip.
         if (state_q == START) begin
            r_q <= '0;
            c_q <= '0;
            s_q <= '0;
         end else if (fire) begin
            if (r_q == r_max) begin
               r_q <= '0;
               if (c_q == c_max) begin
                  c_q <= '0;
                  s_q <= s_q + 3'd1;
               end else begin
                  c_q <= c_q + 5'd1;
               end
            end else begin
               r_q <= r_q + 3'd1;
            end
         end
      end
   end

   assign bus.ref_rd_en_o = rd_en;
   assign bus.ref_x_o     = rd_en ? COORD_W'(c_q) : '0;
   assign bus.ref_y_o     = rd_en ? (COORD_W'({s_q, 2'b00}) + COORD_W'(r_q)
                                     + COORD_W'(fracy_q == 3'd0)) : '0;
   assign bus.fracx_o     = fracx_q;
   assign bus.fracy_o     = fracy_q;
   assign bus.ref_valid_o = valid_q;
   assign bus.refuv_p0_o  = valid_q ? bus.ref_data_i[0*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
   assign bus.refuv_p1_o  = valid_q ? bus.ref_data_i[1*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
   assign bus.refuv_p2_o  = valid_q ? bus.ref_data_i[2*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
   assign bus.refuv_p3_o  = valid_q ? bus.ref_data_i[3*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;

`ifdef MC_CHROMA_FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (state_q == START) begin
         stall_cnt_q <= '0;
      end else if (rd_en && !bus.ref_gnt_i && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mc_chroma_ref_fetch.sv
// Directed self-checking bench for mc_chroma_ref_fetch.
module tb_mc_chroma_ref_fetch;
   localparam int PW = 8;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mc_chroma_ref_fetch_if #(.PIXEL_WIDTH(PW), .COORD_W(CW)) bus ();
   mc_chroma_ref_fetch #(.PIXEL_WIDTH(PW), .COORD_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int failures = 0;

   int r_beats, r_dones, r_blk_starts, r_blk_start, r_first_valid, r_last_valid, r_done_cyc;
   int r_last_x, r_last_y;

   function automatic logic [7:0] pix(input int x, input int y, input int n);
      return 8'((x + n) * 37 + y * 5 + n);
   endfunction

   task automatic run_block(input int wc, input int hc, input int fx, input int fy,
                            input int stall_at, input int stall_len,
                            input int restart_at, input int rst_at);
      int es = 0, ec = 0, er = 0, idx = 0, px = 0, py = 0;
      int stall_left = 0, cyc = 0, post = -1, exp_x, exp_y;
      int W = 4 << wc;
      int R = (fy != 0) ? 7 : 4;
      bit pend = 0, stalled = 0, aborted = 0, finished = 0;
      logic [31:0] exp_taps, got_taps;
      r_beats = 0; r_dones = 0; r_blk_starts = 0; r_blk_start = -1;
      r_first_valid = -1; r_last_valid = -1; r_done_cyc = -1; r_last_x = -1; r_last_y = -1;
      @(negedge clk);
      bus.blk_w_i = 2'(wc); bus.blk_h_i = 2'(hc);
      bus.fracx_i = 3'(fx); bus.fracy_i = 3'(fy);
      bus.start_i = 1'b1;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         bus.start_i = 1'b0;
         bus.ref_data_i = pend ? {pix(px, py, 3), pix(px, py, 2), pix(px, py, 1), pix(px, py, 0)}
                               : 32'hDEAD_BEEF;
         #1;
         if (rst) begin
            checks++;
            if ({bus.ref_rd_en_o, bus.ref_x_o, bus.ref_y_o, bus.blk_start_o, bus.fracx_o,
                 bus.fracy_o, bus.ref_valid_o, bus.refuv_p0_o, bus.refuv_p1_o, bus.refuv_p2_o,
                 bus.refuv_p3_o, bus.busy_o, bus.done_o} !== '0)
               $display("FAIL rst_outputs got rd=%b x=%0d y=%0d valid=%b busy=%b done=%b fx=%0d required all 0",
                        bus.ref_rd_en_o, bus.ref_x_o, bus.ref_y_o, bus.ref_valid_o, bus.busy_o,
                        bus.done_o, bus.fracx_o);
            if ({bus.ref_rd_en_o, bus.ref_x_o, bus.ref_y_o, bus.blk_start_o, bus.fracx_o,
                 bus.fracy_o, bus.ref_valid_o, bus.refuv_p0_o, bus.refuv_p1_o, bus.refuv_p2_o,
                 bus.refuv_p3_o, bus.busy_o, bus.done_o} !== '0) failures++;
            rst = 1'b0;
            post = 6;
         end
         got_taps = {bus.refuv_p3_o, bus.refuv_p2_o, bus.refuv_p1_o, bus.refuv_p0_o};
         checks++;
         if (bus.ref_valid_o !== pend) begin
            failures++;
            $display("FAIL valid cyc=%0d got=%b required=%b", cyc, bus.ref_valid_o, pend);
         end
         exp_taps = pend ? {pix(px, py, 3), pix(px, py, 2), pix(px, py, 1), pix(px, py, 0)} : 32'h0;
         checks++;
         if (got_taps !== exp_taps) begin
            failures++;
            $display("FAIL taps cyc=%0d got=%h required=%h", cyc, got_taps, exp_taps);
         end
         if (pend) begin
            r_beats++;
            if (r_first_valid < 0) r_first_valid = cyc;
            r_last_valid = cyc;
            checks++;
            if (bus.busy_o !== 1'b1) begin
               failures++;
               $display("FAIL busy_during_block cyc=%0d got=%b required=1", cyc, bus.busy_o);
            end
         end
         if (bus.blk_start_o === 1'b1) begin r_blk_starts++; r_blk_start = cyc; end
         if (bus.done_o === 1'b1) begin
            r_dones++; r_done_cyc = cyc;
            if (post < 0) post = 3;
         end
         if (r_blk_starts > 0 && !aborted) begin
            checks++;
            if (bus.fracx_o !== 3'(fx) || bus.fracy_o !== 3'(fy)) begin
               failures++;
               $display("FAIL frac_hold cyc=%0d got=(%0d,%0d) required=(%0d,%0d)",
                        cyc, bus.fracx_o, bus.fracy_o, fx, fy);
            end
         end
         if (restart_at >= 0 && pend && r_beats == restart_at) begin
            bus.start_i = 1'b1;
            bus.blk_w_i = 2'(wc ^ 1); bus.fracx_i = 3'(fx ^ 7); bus.fracy_i = 3'd0;
         end
         if (rst_at >= 0 && pend && r_beats == rst_at && !aborted) begin
            rst = 1'b1;
            aborted = 1;
         end
         pend = 0;
         bus.ref_gnt_i = 1'b1;
         if (bus.ref_rd_en_o === 1'b1) begin
            exp_x = ec;
            exp_y = 4 * es + er + ((fy == 0) ? 1 : 0);
            checks++;
            if (bus.ref_x_o !== CW'(exp_x) || bus.ref_y_o !== CW'(exp_y)) begin
               failures++;
               $display("FAIL addr idx=%0d got=(%0d,%0d) required=(%0d,%0d)",
                        idx, bus.ref_x_o, bus.ref_y_o, exp_x, exp_y);
            end
            if (idx == stall_at && !stalled) begin stall_left = stall_len; stalled = 1; end
            if (stall_left > 0) begin
               bus.ref_gnt_i = 1'b0;
               stall_left--;
            end else begin
               pend = 1; px = exp_x; py = exp_y;
               r_last_x = bus.ref_x_o; r_last_y = bus.ref_y_o;
               idx++;
               if (er == R - 1) begin
                  er = 0;
                  if (ec == W - 1) begin ec = 0; es++; end else ec++;
               end else er++;
            end
         end
         if (aborted) pend = 0;
         if (post > 0) begin
            post--;
            if (post == 0) finished = 1;
         end
      end
      bus.ref_gnt_i = 1'b1;
      checks++;
      if (!finished) begin
         failures++;
         $display("FAIL timeout cyc=%0d got=no_completion required=completion", cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.ref_rd_en_o, bus.ref_valid_o, bus.busy_o, bus.done_o, bus.blk_start_o,
           bus.ref_x_o, bus.ref_y_o, bus.fracx_o, bus.fracy_o, bus.refuv_p0_o} !== '0) begin
         failures++;
         $display("FAIL reset_state got rd=%b valid=%b busy=%b done=%b y=%0d required all 0",
                  bus.ref_rd_en_o, bus.ref_valid_o, bus.busy_o, bus.done_o, bus.ref_y_o);
      end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (bus.ref_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got valid=%b busy=%b required=0,0", bus.ref_valid_o, bus.busy_o);
      end
   endtask

   task automatic test_fy0_basic();
      run_block(0, 0, 0, 0, -1, 0, -1, -1);
      checks++;
      if (r_beats !== 16) begin failures++; $display("FAIL fy0_beats got=%0d required=16", r_beats); end
      checks++;
      if (r_last_valid - r_first_valid !== 15) begin
         failures++; $display("FAIL fy0_consecutive got=%0d required=15", r_last_valid - r_first_valid);
      end
      checks++;
      if (r_dones !== 1 || r_done_cyc !== r_last_valid + 1) begin
         failures++;
         $display("FAIL fy0_done got=count %0d at %0d required=1 at %0d", r_dones, r_done_cyc, r_last_valid + 1);
      end
      checks++;
      if (r_last_x !== 3 || r_last_y !== 4) begin
         failures++; $display("FAIL fy0_last_addr got=(%0d,%0d) required=(3,4)", r_last_x, r_last_y);
      end
      checks++;
      if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL fy0_idle_busy got=%b required=0", bus.busy_o); end
   endtask

   task automatic test_fy3_frac();
      run_block(0, 0, 5, 3, -1, 0, -1, -1);
      checks++;
      if (r_beats !== 28) begin failures++; $display("FAIL fy3_beats got=%0d required=28", r_beats); end
      checks++;
      if (r_first_valid - r_blk_start < 2) begin
         failures++; $display("FAIL fy3_start_gap got=%0d required>=2", r_first_valid - r_blk_start);
      end
      checks++;
      if (r_blk_starts !== 1 || r_dones !== 1) begin
         failures++; $display("FAIL fy3_pulses got=start %0d done %0d required=1,1", r_blk_starts, r_dones);
      end
      checks++;
      if (bus.fracx_o !== 3'd5 || bus.fracy_o !== 3'd3) begin
         failures++; $display("FAIL fy3_frac_idle got=(%0d,%0d) required=(5,3)", bus.fracx_o, bus.fracy_o);
      end
   endtask

   task automatic test_h8_strips();
      run_block(0, 1, 2, 1, -1, 0, -1, -1);
      checks++;
      if (r_beats !== 56) begin failures++; $display("FAIL h8_beats got=%0d required=56", r_beats); end
      checks++;
      if (r_last_x !== 3 || r_last_y !== 10) begin
         failures++; $display("FAIL h8_last_addr got=(%0d,%0d) required=(3,10)", r_last_x, r_last_y);
      end
      checks++;
      if (r_done_cyc !== r_last_valid + 1) begin
         failures++; $display("FAIL h8_done got=%0d required=%0d", r_done_cyc, r_last_valid + 1);
      end
   endtask

   task automatic test_stall();
      run_block(0, 0, 0, 2, 5, 3, -1, -1);
      checks++;
      if (r_beats !== 28) begin failures++; $display("FAIL stall_beats got=%0d required=28", r_beats); end
      checks++;
      if (r_last_valid - r_first_valid !== 30) begin
         failures++; $display("FAIL stall_span got=%0d required=30", r_last_valid - r_first_valid);
      end
`ifdef MC_CHROMA_FETCH_STALL_CNT_EN
      checks++;
      if (bus.stall_cnt_o !== 16'd3) begin
         failures++; $display("FAIL stall_cnt got=%0d required=3", bus.stall_cnt_o);
      end
`endif
   endtask

   task automatic test_back_to_back_start();
      run_block(1, 0, 2, 4, -1, 0, 10, -1);
      checks++;
      if (r_beats !== 56) begin failures++; $display("FAIL restart_beats got=%0d required=56", r_beats); end
      checks++;
      if (r_dones !== 1 || r_blk_starts !== 1) begin
         failures++; $display("FAIL restart_pulses got=start %0d done %0d required=1,1", r_blk_starts, r_dones);
      end
   endtask

   task automatic test_abort();
      run_block(1, 0, 1, 1, -1, 0, -1, 12);
      checks++;
      if (r_dones !== 0) begin failures++; $display("FAIL abort_done got=%0d required=0", r_dones); end
      checks++;
      if (r_beats !== 12) begin failures++; $display("FAIL abort_beats got=%0d required=12", r_beats); end
      run_block(0, 0, 3, 2, -1, 0, -1, -1);
      checks++;
      if (r_beats !== 28 || r_blk_starts !== 1 || r_dones !== 1) begin
         failures++;
         $display("FAIL after_abort got=beats %0d starts %0d dones %0d required=28,1,1",
                  r_beats, r_blk_starts, r_dones);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start_i = 1'b0; bus.blk_w_i = '0; bus.blk_h_i = '0;
      bus.fracx_i = '0; bus.fracy_i = '0; bus.ref_gnt_i = 1'b1; bus.ref_data_i = '0;
      test_reset();
      test_fy0_basic();
      test_fy3_frac();
      test_h8_strips();
      test_stall();
      test_back_to_back_start();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mc_chroma_ref_fetch.md
Name: mc_chroma_ref_fetch

Overview:
- Upstream feeder for the single-pixel-per-cycle chroma fractional interpolator.
- Reads padded chroma reference pixels from the MC reference buffer and emits one 4-tap horizontal window (p0..p3) per valid cycle.
- Output order is column-major within 4-row strips, which is the sequence the downstream vertical shift register expects.
- Supplies block start, fracx and fracy alongside the data stream, and signals completion.

Parameters:
- PIXEL_WIDTH, 8, bits per chroma sample.
- COORD_W, 6, width of the reference-buffer x/y address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to process a block; ignored unless idle.
- blk_w_i  in  2  block width code: 0=4, 1=8, 2=16, 3=32 pixels.
- blk_h_i  in  2  block height code, same encoding; height is always a multiple of 4.
- fracx_i  in  3  horizontal fractional MV; latched on accepted start.
- fracy_i  in  3  vertical fractional MV; latched on accepted start.
- ref_rd_en_o  out  1  reference buffer read request.
- ref_x_o  out  COORD_W  column of the leftmost tap in the padded buffer (buffer column 0 = block x-1).
- ref_y_o  out  COORD_W  padded buffer row (row 0 = block y-1).
- ref_gnt_i  in  1  read granted this cycle; data returns exactly 1 cycle later.
- ref_data_i  in  4*PIXEL_WIDTH  {p3,p2,p1,p0} at (ref_x_o..ref_x_o+3, ref_y_o).
- blk_start_o  out  1  one-cycle pulse that clears the downstream counters.
- fracx_o  out  3  latched fracx, held stable for the whole block.
- fracy_o  out  3  latched fracy, held stable for the whole block.
- ref_valid_o  out  1  window valid.
- refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o  out  PIXEL_WIDTH each  window taps.
- busy_o  out  1  block in progress.
- done_o  out  1  one-cycle pulse after the last window is emitted.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE; ref_valid_o stays 0 on the cycle after reset deasserts.
- Reset asserted mid-block aborts the block immediately: no done_o, and any in-flight read data is discarded.
- FSM states and transitions:
  - IDLE: start_i latches W, H, fracx and fracy, then goes to START.
  - START: blk_start_o=1 for exactly one cycle, then FETCH.
  - FETCH: issues reads until the last address is granted, then DRAIN.
  - DRAIN: waits one cycle, then DONE.
  - DONE: done_o=1 for one cycle, then IDLE.
  - busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored; the latched parameters do not change.
- Counters: strip s = 0..H/4-1, column c = 0..W-1, row r = 0..R-1.
  - R=7 if fracy!=0, R=4 if fracy==0.
  - Nesting order is r (innermost), then c, then s.
- Addresses: ref_x_o = c; ref_y_o = 4s + r + (fracy==0 ? 1 : 0).
- Counters advance only on (ref_rd_en_o & ref_gnt_i). When ref_gnt_i=0, ref_rd_en_o stays high and the address holds.
- ref_valid_o is a registered copy of (ref_rd_en_o & ref_gnt_i). refuv_pN_o are driven directly from ref_data_i, so data aligns with ref_valid_o.
- When ref_valid_o=0, refuv_pN_o are 0.
- Throughput with no stalls: W*(H/4)*R valid beats, one per cycle.
- The first valid beat occurs no earlier than 2 cycles after blk_start_o. This guarantees the downstream valid clear lands first.
- done_o is asserted exactly 1 cycle after the final ref_valid_o.
- fracx_o and fracy_o update in the START cycle and hold until the next accepted start, including while idle.
- Max coordinates: x = W+2 ≤ 34; y = H+2 ≤ 34. Both fit COORD_W=6.

Optional Feature:
- MC_CHROMA_FETCH_STALL_CNT_EN defined: adds output stall_cnt_o[15:0].
  - Counts cycles with ref_rd_en_o=1 and ref_gnt_i=0.
  - Cleared to 0 in the START cycle; saturates at 16'hFFFF.
  - Holds its value after done_o until the next start.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
- W=4, H=4, fracy=0, gnt always 1: addresses (x,y) = (0,1),(0,2),(0,3),(0,4),(1,1)..(3,4).
  - 16 valid beats on consecutive cycles; done_o 1 cycle after the 16th.
- W=4, H=4, fracy=3, fracx=5: column 0 reads rows 0..6, then column 1 rows 0..6, and so on.
  - 28 beats; fracx_o=5 and fracy_o=3 stable throughout.
  - blk_start_o precedes the first beat by ≥2 cycles.
- W=4, H=8, fracy=1: 56 beats; strip 1 column 0 reads rows 4..10.
  - Last address is (3,10).
- W=4, H=4, fracy=2, ref_gnt_i low for 3 cycles at beat 5: address held at (0,5) during the stall.
  - No ref_valid_o for 3 cycles; beat order unchanged; total still 28.
  - With MC_CHROMA_FETCH_STALL_CNT_EN, stall_cnt_o=3.
- start_i pulsed again at beat 10 of a W=8 block: ignored; the block completes with 8*7=56 beats (fracy!=0) and a single done_o.
- rst asserted at beat 12: all outputs 0 next cycle, no done_o.
  - A new start then produces a fresh blk_start_o and the full beat sequence from (0,0).
